// File: rtl/ternary_stream_driver.sv
`default_nettype none
// ============================================================================
// Module   : ternary_stream_driver
// Purpose  : Buffers a ternary weight set, loads it into the matrix multiplier
//            after a short reset, then streams activation vectors row by row
//            and captures the tagged results returned on tt_out.
// Revision : 1.0 - initial release
// ============================================================================
module ternary_stream_driver #(
  parameter int IN_LEN  = 14,
  parameter int OUT_LEN = 7,
  parameter int RES_LAT = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wt_valid,
  output logic                       wt_ready,
  input  logic [IN_LEN-1:0]          wt_data,
  input  logic                       vec_valid,
  output logic                       vec_ready,
  input  logic [15:0]                vec_data,
  input  logic                       start,
  output logic                       busy,
  output logic                       tt_rst_n,
  output logic [15:0]                tt_in,
  input  logic [7:0]                 tt_out,
  output logic                       res_valid,
  output logic [$clog2(OUT_LEN)-1:0] res_row,
  output logic [7:0]                 res_data
);

  localparam int NHALF = 2 * OUT_LEN;
  localparam int ROW_W = $clog2(OUT_LEN);
  localparam int IDX_W = $clog2(NHALF + 1);
  localparam int CNT_W = ROW_W + 1;
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(OUT_LEN - 1);
  localparam logic [CNT_W-1:0] LOAD_LAST = {1'b1, ROW_LAST};
  localparam logic [IDX_W-1:0] IDX_FULL  = IDX_W'(NHALF);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FILL = 3'd1,
    S_RST  = 3'd2,
    S_LOAD = 3'd3,
    S_RUN  = 3'd4
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [IDX_W-1:0]   wr_idx;
  logic               buf_full;
  logic               wt_fire;
  logic [IN_LEN-1:0]  buffer [NHALF];
  logic               rst_cnt;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_nx;
  logic [ROW_W-1:0]   row;
  logic [IDX_W-1:0]   load_idx;
  logic [15:0]        load_word;
  logic [15:0]        vec_hold;
  logic               vec_hold_valid;
  logic [ROW_W-1:0]   issue_row;
  logic [RES_LAT-1:0] tag_valid;
  logic [ROW_W-1:0]   tag_row [RES_LAT];

  // The schedule counter's low field is the row; its top bit marks the
  // second (high-half) pass, so the field value OUT_LEN..max is skipped.
  assign row      = count[ROW_W-1:0];
  assign count_nx = (row == ROW_LAST) ? {~count[ROW_W], {ROW_W{1'b0}}}
                                      : count + CNT_W'(1);
  assign load_idx = count[ROW_W] ? (IDX_W'(OUT_LEN) + IDX_W'(row)) : IDX_W'(row);
  assign buf_full = (wr_idx == IDX_FULL);
  assign wt_fire  = wt_valid && wt_ready;

  // Results are reported straight from the multiplier bus, qualified by the tag.
  assign res_valid = tag_valid[RES_LAT-1];
  assign res_row   = res_valid ? tag_row[RES_LAT-1] : '0;
  assign res_data  = res_valid ? tt_out : '0;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode and state-derived outputs (no input reaches an output).
  always_comb begin
    state_nx  = state;
    wt_ready  = 1'b0;
    vec_ready = 1'b0;
    busy      = 1'b0;
    tt_rst_n  = 1'b0;
    tt_in     = '0;
    load_word = '0;
    load_word[IN_LEN-1:0] = buffer[load_idx];
    case (state)
      S_IDLE: begin
        wt_ready = 1'b1;
        if (wt_valid) state_nx = S_FILL;
      end
      S_FILL: begin
        wt_ready = !buf_full;
        if (start && buf_full) state_nx = S_RST;
      end
      S_RST: begin
        busy = 1'b1;
        if (rst_cnt) state_nx = S_LOAD;
      end
      S_LOAD: begin
        busy     = 1'b1;
        tt_rst_n = 1'b1;
        tt_in    = load_word;
        if (count == LOAD_LAST) state_nx = S_RUN;
      end
      S_RUN: begin
        busy      = 1'b1;
        tt_rst_n  = 1'b1;
        vec_ready = (row == '0);
        tt_in     = vec_hold_valid ? vec_hold : '0;
        if (start) state_nx = S_RST;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Write pointer, two-cycle reset timer and the multiplier-mirroring counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx  <= '0;
      rst_cnt <= 1'b0;
      count   <= '0;
    end else begin
      if (wt_fire) wr_idx <= wr_idx + IDX_W'(1);
      rst_cnt <= (state == S_RST);
      if (!tt_rst_n) begin
        count <= '0;
      end else begin
        count <= count_nx;
      end
    end
  end

  // Weight-half buffer, filled in arrival order and discarded on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NHALF; i++) buffer[i] <= '0;
    end else if (wt_fire) begin
      buffer[wr_idx] <= wt_data;
    end
  end

  // Vector hold register: a vector taken on a row-0 cycle drives tt_in for the
  // following OUT_LEN cycles; a missing vector leaves a bubble of zeros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_hold       <= '0;
      vec_hold_valid <= 1'b0;
      issue_row      <= '0;
    end else begin
      issue_row <= row;
      if (state != S_RUN || start) begin
        vec_hold_valid <= 1'b0;
      end else if (vec_ready) begin
        vec_hold_valid <= vec_valid;
        if (vec_valid) vec_hold <= vec_data;
      end
    end
  end

  // Tag pipeline tracking each issued row until its result appears; a restart
  // from RUN flushes every tag still in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_valid <= '0;
      for (int i = 0; i < RES_LAT; i++) tag_row[i] <= '0;
    end else if (state == S_RUN && start) begin
      tag_valid <= '0;
      for (int i = 0; i < RES_LAT; i++) tag_row[i] <= '0;
    end else begin
      tag_valid[0] <= (state == S_RUN) && vec_hold_valid;
      tag_row[0]   <= issue_row;
      for (int i = 1; i < RES_LAT; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_row[i]   <= tag_row[i-1];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ternary_stream_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_ternary_stream_driver
// Purpose  : Randomized scoreboard bench for ternary_stream_driver. The
//            stimulus thread predicts a cycle-stamped timeline of outputs and
//            results; a monitor thread compares the DUT against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ternary_stream_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wt_valid = 1'b0;
  logic        wt_ready;
  logic [13:0] wt_data = '0;
  logic        vec_valid = 1'b0;
  logic        vec_ready;
  logic [15:0] vec_data = '0;
  logic        start = 1'b0;
  logic        busy;
  logic        tt_rst_n;
  logic [15:0] tt_in;
  logic [7:0]  tt_out = '0;
  logic        res_valid;
  logic [2:0]  res_row;
  logic [7:0]  res_data;

  typedef struct {
    int cyc;
    int row;
  } res_t;

  int          cyc    = 0;
  int          checks = 0;
  int          errors = 0;
  int          run0   = 0;
  int          mcount = 0;
  logic [13:0] mbuf [14];
  res_t        res_q [$];
  logic [15:0] exp_tt   [int];
  logic        exp_rstn [int];
  logic        exp_vr   [int];
  logic        exp_wr   [int];
  logic        exp_busy [int];
  logic        exp_rz   [int];

  ternary_stream_driver #(.IN_LEN(14), .OUT_LEN(7), .RES_LAT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .wt_valid  (wt_valid),
    .wt_ready  (wt_ready),
    .wt_data   (wt_data),
    .vec_valid (vec_valid),
    .vec_ready (vec_ready),
    .vec_data  (vec_data),
    .start     (start),
    .busy      (busy),
    .tt_rst_n  (tt_rst_n),
    .tt_in     (tt_in),
    .tt_out    (tt_out),
    .res_valid (res_valid),
    .res_row   (res_row),
    .res_data  (res_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, expv);
    end
  endfunction

  // Monitor: compares every output the timeline predicts for this cycle.
  always @(negedge clk) begin
    if (exp_tt.exists(cyc))   begin check("tt_in", 32'(tt_in), 32'(exp_tt[cyc])); exp_tt.delete(cyc); end
    if (exp_rstn.exists(cyc)) begin check("tt_rst_n", 32'(tt_rst_n), 32'(exp_rstn[cyc])); exp_rstn.delete(cyc); end
    if (exp_vr.exists(cyc))   begin check("vec_ready", 32'(vec_ready), 32'(exp_vr[cyc])); exp_vr.delete(cyc); end
    if (exp_wr.exists(cyc))   begin check("wt_ready", 32'(wt_ready), 32'(exp_wr[cyc])); exp_wr.delete(cyc); end
    if (exp_busy.exists(cyc)) begin check("busy", 32'(busy), 32'(exp_busy[cyc])); exp_busy.delete(cyc); end
    if (exp_rz.exists(cyc)) begin
      check("res_valid_reset", 32'(res_valid), 32'd0);
      check("res_row_reset", 32'(res_row), 32'd0);
      check("res_data_reset", 32'(res_data), 32'd0);
      exp_rz.delete(cyc);
    end
    if (res_valid) begin
      if (res_q.size() == 0) begin
        check("unexpected_result", 32'(res_valid), 32'd0);
      end else begin
        res_t e;
        e = res_q.pop_front();
        check("res_cycle", 32'(cyc), 32'(e.cyc));
        check("res_row", 32'(res_row), 32'(e.row));
        check("res_data", 32'(res_data), 32'(tt_out));
      end
    end else if (res_q.size() > 0 && res_q[0].cyc <= cyc) begin
      check("missing_result", 32'(res_valid), 32'd1);
      void'(res_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    tt_out = 8'($urandom);
  endtask

  function automatic void purge_from(input int c);
    for (int k = c; k < c + 40; k++) begin
      if (exp_tt.exists(k))   exp_tt.delete(k);
      if (exp_rstn.exists(k)) exp_rstn.delete(k);
      if (exp_vr.exists(k))   exp_vr.delete(k);
      if (exp_wr.exists(k))   exp_wr.delete(k);
      if (exp_busy.exists(k)) exp_busy.delete(k);
    end
  endfunction

  function automatic void expect_reset(input int c);
    exp_tt[c]   = 16'h0;
    exp_rstn[c] = 1'b0;
    exp_vr[c]   = 1'b0;
    exp_wr[c]   = 1'b1;
    exp_busy[c] = 1'b0;
    exp_rz[c]   = 1'b1;
  endfunction

  // Offers n weight halves (optionally with random gaps); the model keeps the
  // first 14 halves since reset and refuses anything beyond.
  task automatic write_halves(input int n, input bit fixed);
    int done = 0;
    int guard = 0;
    while (done < n && guard < 200) begin
      wt_valid = fixed ? 1'b1 : ($urandom_range(0, 3) != 0);
      wt_data  = fixed ? 14'(done + 1) : 14'($urandom);
      if (wt_valid) begin
        exp_wr[cyc] = (mcount < 14);
        if (mcount < 14) begin
          mbuf[mcount] = wt_data;
          mcount++;
        end
        done++;
      end
      tick();
      guard++;
    end
    wt_valid = 1'b0;
  endtask

  // Pulses start in the current cycle: two reset cycles, fourteen load cycles
  // replaying the stored halves, then the first row-0 cycle of RUN.
  task automatic start_session();
    int s = cyc;
    purge_from(s + 1);
    while (res_q.size() > 0 && res_q[$].cyc > s) void'(res_q.pop_back());
    start = 1'b1;
    exp_rstn[s+1] = 1'b0;
    exp_rstn[s+2] = 1'b0;
    exp_busy[s+1] = 1'b1;
    exp_tt[s+1]   = 16'h0;
    exp_tt[s+2]   = 16'h0;
    for (int k = 0; k < 14; k++) begin
      exp_tt[s+3+k]   = {2'b00, mbuf[k]};
      exp_rstn[s+3+k] = 1'b1;
    end
    exp_vr[s+16] = 1'b0;
    exp_vr[s+17] = 1'b1;
    exp_tt[s+17] = 16'h0;
    run0 = s + 17;
    tick();
    start = 1'b0;
  endtask

  task automatic go_to(input int t);
    int g = 0;
    while (cyc < t && g < 100) begin
      tick();
      g++;
    end
    check("reached_row0_cycle", 32'(cyc), 32'(t));
  endtask

  // Presents one vector (or a bubble) on a row-0 cycle and predicts its seven
  // issue cycles and the results two cycles after each row.
  task automatic run_vector(input bit valid, input logic [15:0] v, input int stay);
    int c = cyc;
    vec_valid = valid;
    vec_data  = v;
    exp_vr[c]   = 1'b1;
    exp_vr[c+1] = 1'b0;
    exp_wr[c]   = 1'b0;
    exp_busy[c] = 1'b1;
    for (int r = 0; r < 7; r++) begin
      exp_tt[c+1+r] = valid ? v : 16'h0;
      if (valid) res_q.push_back('{c + 3 + r, r});
    end
    for (int i = 0; i < stay; i++) begin
      tick();
      vec_data = 16'($urandom);
    end
    run0 = c + 7;
  endtask

  initial begin
    for (int i = 0; i < 14; i++) mbuf[i] = '0;

    // Reset held, then released.
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_reset(cyc);
    end
    rst = 1'b0;
    expect_reset(cyc);

    // start with an empty buffer is ignored.
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_busy[cyc] = 1'b0;
    exp_rstn[cyc] = 1'b0;
    exp_wr[cyc]   = 1'b1;

    // Halves 0x0001..0x000E back-to-back, then a refused 15th half.
    write_halves(14, 1'b1);
    wt_valid = 1'b1;
    wt_data  = 14'h3FFF;
    exp_wr[cyc]   = 1'b0;
    exp_busy[cyc] = 1'b0;
    tick();
    wt_valid = 1'b0;

    // First session: fixed vector, a bubble, then random traffic.
    start_session();
    go_to(run0);
    run_vector(1'b1, 16'hA55A, 7);
    run_vector(1'b0, 16'($urandom), 7);
    run_vector(1'b1, 16'($urandom), 7);
    for (int i = 0; i < 4; i++) run_vector($urandom_range(0, 3) != 0, 16'($urandom), 7);

    // Restart from RUN with two rows still in flight; buffer is replayed.
    run_vector(1'b1, 16'($urandom), 3);
    start_session();
    vec_valid = 1'b0;
    go_to(run0);
    run_vector(1'b1, 16'($urandom), 7);
    run_vector(1'b1, 16'($urandom), 7);

    // Reset asserted on LOAD cycle 5.
    vec_valid = 1'b0;
    start_session();
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b1;
    mcount = 0;
    purge_from(cyc);
    res_q.delete();
    expect_reset(cyc);
    tick();
    expect_reset(cyc);
    rst = 1'b0;
    expect_reset(cyc);

    // After reset, start is ignored until a full set of 14 halves is written.
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_busy[cyc] = 1'b0;
    exp_rstn[cyc] = 1'b0;
    write_halves(13, 1'b0);
    start = 1'b1;
    exp_wr[cyc] = 1'b1;
    tick();
    start = 1'b0;
    exp_busy[cyc] = 1'b0;
    tick();
    exp_busy[cyc] = 1'b0;
    write_halves(1, 1'b0);
    start_session();
    go_to(run0);
    for (int i = 0; i < 3; i++) run_vector($urandom_range(0, 3) != 0, 16'($urandom), 7);

    vec_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("results_drained", 32'(res_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/ternary_stream_driver.md
TERNARY_STREAM_DRIVER -- requirements
Module: ternary_stream_driver

Interface
REQ-001 Parameter IN_LEN, default 14: ternary weights per row; one weight word is 2*IN_LEN = 28 bits, sent as two 14-bit halves.
REQ-002 Parameter OUT_LEN, default 7: matrix rows, and the number of row cycles per vector.
REQ-003 Parameter RES_LAT, default 2: cycles from row issue on tt_in to a valid result on tt_out.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 wt_valid / wt_ready / wt_data  in / out / in  1 / 1 / 14  weight-half write handshake.
REQ-007 vec_valid / vec_ready / vec_data  in / out / in  1 / 1 / 16  activation vector handshake.
REQ-008 start  input  1  begins a load-then-run session.
REQ-009 busy  output  1  high in any state other than IDLE or FILL.
REQ-010 tt_rst_n  output  1  active-low reset driven to the multiplier.
REQ-011 tt_in  output  16  drives the multiplier input bus {ui_in, uio_in}.
REQ-012 tt_out  input  8  multiplier result bus (uo_out).
REQ-013 res_valid / res_row / res_data  out / out / out  1 / 3 / 8  captured result, its row index, and its data.

Function
REQ-014 FSM states: IDLE, FILL, RST, LOAD, RUN.
REQ-015 IDLE -> FILL on wt_valid. FILL stores 2*OUT_LEN = 14 halves in a buffer, in index order 0..13.
- wt_ready is high in IDLE and in FILL while the buffer is not full.
- A transfer occurs when wt_valid && wt_ready.
REQ-016 A full buffer is held in FILL with wt_ready low. start while the buffer is full -> RST. start is ignored in every other case.
REQ-017 RST: tt_rst_n is low for exactly 2 cycles, then LOAD.
REQ-018 LOAD lasts exactly 14 cycles, starting on the first cycle tt_rst_n is high.
- On LOAD cycle k, tt_in[13:0] = buffer[k] and tt_in[15:14] = 0.
- Halves 0..6 are the low halves of rows 0..6; halves 7..13 are the high halves.
REQ-019 The internal schedule counter mirrors the multiplier:
- count[2:0] steps 0..6, skipping 7 (6 -> 8, 14 -> 0).
- The counter resets to 0 whenever tt_rst_n is low.
REQ-020 RUN starts on the cycle after the 14th LOAD cycle, with row = count[2:0] = 0.
REQ-021 Vector acceptance:
- vec_ready is high in RUN only on row-0 cycles.
- An accepted vector is held on tt_in for rows 0..6, 7 cycles in all.
REQ-022 If vec_valid is low on a row-0 cycle, the driver issues a bubble:
- tt_in = 0 for 7 cycles;
- no results are reported for those rows.
REQ-023 Result capture:
- For each non-bubble row r issued on cycle t, the driver asserts res_valid for one cycle at t+RES_LAT with res_row = r and res_data = tt_out.
- An in-flight tag pipeline of depth RES_LAT carries {valid, row}.
REQ-024 start in RUN -> RST:
- the buffer is reused;
- in-flight result tags are flushed and not reported.
REQ-025 A new weight set may be written only in IDLE/FILL. RUN exits to IDLE only on rst.
REQ-026 No combinational path from any input to any output except tt_out -> res_data.

Reset
REQ-027 While rst is high, and on its deassertion:
- state = IDLE, buffer index = 0, schedule counter = 0, tag pipeline cleared;
- tt_rst_n = 0, tt_in = 0, res_valid = 0, res_row = 0, res_data = 0, busy = 0, wt_ready = 1, vec_ready = 0.
REQ-028 rst asserted in any state, including mid-LOAD or mid-RUN, aborts immediately to the reset values; buffer contents are discarded.

Verification
REQ-029 Write halves 0x0001..0x000E back-to-back, then pulse start.
- Response: tt_rst_n low for 2 cycles.
- Then tt_in[13:0] = 0x0001..0x000E on 14 consecutive cycles.
- Then vec_ready is high on the next cycle.
REQ-030 In RUN, present vec_data = 0xA55A with vec_valid held high.
- Response: tt_in = 0xA55A for 7 cycles.
- res_valid pulses with res_row = 0..6, each pulse RES_LAT = 2 cycles after its row issue.
- res_data equals tt_out on those cycles.
REQ-031 vec_valid low at a row-0 cycle.
- Response: tt_in = 0 for 7 cycles and no res_valid for those rows.
- The next valid vector is accepted at the following row-0 cycle.
REQ-032 Write a 15th half while the buffer is full.
- Response: wt_ready is 0, and the buffer is unchanged (verified by replaying LOAD).
REQ-033 Assert rst on LOAD cycle 5.
- Response: all outputs are at reset values on the same cycle, and state = IDLE.
- After rst is released, 14 new halves must be written before start is honoured.
REQ-034 start during RUN with 2 results in flight.
- Response: neither result is reported.
- tt_rst_n goes low for 2 cycles, then the stored halves are reloaded in order.
